// File: rtl/i2c_master_cmd.sv
// Byte-level I2C bus master: runs START / WRITE / READ / STOP commands on SCL/SDA
// with quarter-bit timing derived from the system clock.
module i2c_master_cmd #(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int I2C_HZ     = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       m_nack,
  output logic [7:0] rx_data,
  output logic       ack_in,
  output logic       err,
  output logic       done,
  output logic       busy,
  output logic       SCL,
  inout  wire        SDA
);

  localparam int QTR   = SYS_CLK_HZ / (4 * I2C_HZ);
  localparam int CNT_W = (QTR > 1) ? $clog2(QTR) : 1;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_START, S_WBIT, S_WACK, S_RBIT, S_MACK, S_STOP, S_HOLD
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         qtr;
  logic [2:0]         bit_cnt;
  logic [7:0]         tx_sh;
  logic [7:0]         rx_sh;
  logic [1:0]         cmd_r;
  logic               m_nack_r;
  logic               from_idle;
  logic               ack_smp;
  logic               sda_p0, sda_p1;
  logic               scl_q, sda_low_q;
  logic               scl_d, sda_low_d;
  logic               run, tick, step_end, accept, scl_bit;

  assign cmd_ready = (state == S_IDLE) || (state == S_HOLD);
  assign accept    = cmd_valid && cmd_ready;
  assign run       = (state inside {S_START, S_WBIT, S_WACK, S_RBIT, S_MACK, S_STOP});
  assign tick      = run && (cnt == CNT_W'(QTR - 1));
  assign step_end  = tick && (qtr == 2'd3);
  // Data-bit SCL shape: high only in the two middle quarters.
  assign scl_bit   = qtr[0] ^ qtr[1];

  assign SCL = scl_q;
  assign SDA = sda_low_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_d     = scl_q;
    sda_low_d = sda_low_q;
    case (state)
      S_IDLE: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        if (cmd_valid) state_nxt = S_DECODE;
      end
      S_HOLD: begin
        scl_d = 1'b0;
        if (cmd_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (cmd_r == CMD_START) state_nxt = S_START;
        else if (!busy)         state_nxt = S_IDLE;
        else if (cmd_r == CMD_WRITE) state_nxt = S_WBIT;
        else if (cmd_r == CMD_READ)  state_nxt = S_RBIT;
        else                         state_nxt = S_STOP;
      end
      S_START: begin
        scl_d     = (qtr == 2'd0) ? from_idle : (qtr != 2'd3);
        sda_low_d = qtr[1];
        if (step_end) state_nxt = S_HOLD;
      end
      S_WBIT: begin
        scl_d     = scl_bit;
        sda_low_d = ~tx_sh[7];
        if (step_end && bit_cnt == 3'd7) state_nxt = S_WACK;
      end
      S_WACK: begin
        scl_d     = scl_bit;
        sda_low_d = 1'b0;
        if (step_end) state_nxt = S_HOLD;
      end
      S_RBIT: begin
        scl_d     = scl_bit;
        sda_low_d = 1'b0;
        if (step_end && bit_cnt == 3'd7) state_nxt = S_MACK;
      end
      S_MACK: begin
        scl_d     = scl_bit;
        sda_low_d = ~m_nack_r;
        if (step_end) state_nxt = S_HOLD;
      end
      S_STOP: begin
        scl_d     = (qtr != 2'd0);
        sda_low_d = ~qtr[1];
        if (step_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      qtr       <= 2'd0;
      bit_cnt   <= 3'd0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      cmd_r     <= CMD_START;
      m_nack_r  <= 1'b0;
      from_idle <= 1'b0;
      ack_smp   <= 1'b0;
      rx_data   <= 8'h00;
      ack_in    <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      sda_p0    <= 1'b1;
      sda_p1    <= 1'b1;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      done      <= 1'b0;
      sda_p0    <= SDA;
      sda_p1    <= sda_p0;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
      if (run)  cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) qtr <= qtr + 2'd1;
      if (accept) begin
        cmd_r    <= cmd;
        tx_sh    <= tx_data;
        m_nack_r <= m_nack;
      end
      case (state)
        S_DECODE: begin
          bit_cnt   <= 3'd0;
          from_idle <= !busy;
          // Data or STOP commands with no bus held finish at once, untouched bus.
          if (cmd_r != CMD_START && !busy) begin
            done <= 1'b1;
            err  <= (cmd_r != CMD_STOP);
          end
        end
        S_START: if (step_end) begin
          done <= 1'b1;
          err  <= 1'b0;
          busy <= 1'b1;
        end
        S_WBIT: if (step_end) begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sh   <= {tx_sh[6:0], 1'b0};
        end
        S_WACK: begin
          if (tick && qtr == 2'd1) ack_smp <= sda_p1;
          if (step_end) begin
            done   <= 1'b1;
            err    <= 1'b0;
            ack_in <= ack_smp;
          end
        end
        S_RBIT: begin
          if (tick && qtr == 2'd1) rx_sh <= {rx_sh[6:0], sda_p1};
          if (step_end) bit_cnt <= bit_cnt + 3'd1;
        end
        S_MACK: if (step_end) begin
          done    <= 1'b1;
          err     <= 1'b0;
          rx_data <= rx_sh;
        end
        S_STOP: if (step_end) begin
          done <= 1'b1;
          err  <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_cmd.sv
// Directed bench for i2c_master_cmd with a pulled-up SDA line and a two-device
// slave model (LED at 0x64 latches written data, MEM at 0x66 returns a fixed byte).
module tb_i2c_master_cmd;

  localparam int QTR = 250;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_WRITE = 2'b01;
  localparam logic [1:0] C_READ  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;
  localparam logic [6:0] LED_ADR = 7'h64;
  localparam logic [6:0] MEM_ADR = 7'h66;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] tx_data;
  logic       m_nack;
  logic [7:0] rx_data;
  logic       ack_in, err, done, busy, scl;
  wire        sda;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc = 0;
  int lat;

  i2c_master_cmd dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .tx_data(tx_data), .m_nack(m_nack), .rx_data(rx_data),
    .ack_in(ack_in), .err(err), .done(done), .busy(busy), .SCL(scl), .SDA(sda)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model, sampled on the falling system clock
  typedef enum logic [1:0] {P_NONE, P_ADDR, P_WDATA, P_RDATA} phase_t;
  phase_t     phase = P_NONE;
  int         bcnt = 0;
  logic [7:0] shift = 8'h00;
  logic [7:0] led_reg = 8'h00;
  logic [7:0] mem_byte = 8'h5A;
  logic       s_drive = 1'b0;
  logic       s_rw = 1'b0;
  logic       s_led = 1'b0;
  logic       s_scl = 1'b1;
  logic       s_sda = 1'b1;

  assign sda = s_drive ? 1'b0 : 1'bz;
  pullup (sda);

  always @(negedge clk) begin
    s_scl <= scl;
    s_sda <= sda;
    if (s_scl && scl && s_sda && !sda) begin
      phase <= P_ADDR; bcnt <= 0; s_drive <= 1'b0;
    end else if (s_scl && scl && !s_sda && sda) begin
      phase <= P_NONE; s_drive <= 1'b0;
    end else if (!s_scl && scl) begin
      if ((phase == P_ADDR || phase == P_WDATA) && bcnt < 8) shift <= {shift[6:0], sda};
      if (phase == P_RDATA && bcnt == 8 && sda) phase <= P_NONE;
      bcnt <= bcnt + 1;
    end else if (s_scl && !scl) begin
      case (phase)
        P_ADDR:
          if (bcnt == 8) begin
            if (shift[7:1] == LED_ADR || shift[7:1] == MEM_ADR) begin
              s_led <= (shift[7:1] == LED_ADR); s_rw <= shift[0]; s_drive <= 1'b1;
            end else begin
              phase <= P_NONE; s_drive <= 1'b0;
            end
          end else if (bcnt == 9) begin
            bcnt <= 0;
            if (s_rw) begin phase <= P_RDATA; s_drive <= ~mem_byte[7]; end
            else begin phase <= P_WDATA; s_drive <= 1'b0; end
          end
        P_WDATA:
          if (bcnt == 8) begin
            s_drive <= 1'b1;
            if (s_led) led_reg <= shift;
          end else if (bcnt == 9) begin
            bcnt <= 0; s_drive <= 1'b0;
          end
        P_RDATA:
          if (bcnt < 8) s_drive <= ~mem_byte[7 - bcnt];
          else if (bcnt == 8) s_drive <= 1'b0;
          else begin bcnt <= 0; s_drive <= ~mem_byte[7]; end
        default: s_drive <= 1'b0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d, input logic mn);
    cmd = c; tx_data = d; m_nack = mn; cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  // Waits for done with a cycle bound; optionally pokes a request mid-command.
  task automatic wait_done(output int l, input int poke_at);
    int n;
    n = 0;
    l = -1;
    while (n < 40 * QTR) begin
      @(posedge clk); #1;
      n++;
      if (n == poke_at) begin cmd = C_STOP; cmd_valid = 1'b1; end
      if (n == poke_at + 100) cmd_valid = 1'b0;
      if (done) begin l = cyc - acc; break; end
    end
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd = C_START; tx_data = 8'h00; m_nack = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ack", ack_in, 0);
    chk("rst_rx", rx_data, 8'h00);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_ready", cmd_ready, 1);

    // Write to LED slave
    send(C_START, 8'h00, 1'b0);
    chk("ready_drop", cmd_ready, 0);
    wait_done(lat, -1);
    chk("start_lat", lat, 4 * QTR + 1);
    chk("start_busy", busy, 1);
    chk("ready_at_done", cmd_ready, 1);
    chk("start_err", err, 0);
    send(C_WRITE, 8'hC8, 1'b0);
    wait_done(lat, -1);
    chk("wr_addr_lat", lat, 36 * QTR + 1);
    chk("wr_addr_ack", ack_in, 0);
    send(C_WRITE, 8'h3C, 1'b0);
    wait_done(lat, 3000);
    chk("wr_poke_lat", lat, 36 * QTR + 1);
    chk("wr_data_ack", ack_in, 0);
    chk("wr_busy", busy, 1);
    chk("wr_err", err, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    send(C_STOP, 8'h00, 1'b0);
    wait_done(lat, -1);
    chk("stop_lat", lat, 4 * QTR + 1);
    chk("stop_busy", busy, 0);
    chk("stop_scl", scl, 1);
    chk("stop_sda", sda, 1);
    chk("led_reg", led_reg, 8'h3C);

    // Absent address
    send(C_START, 8'h00, 1'b0);
    wait_done(lat, -1);
    send(C_WRITE, 8'hFE, 1'b0);
    wait_done(lat, -1);
    chk("absent_ack", ack_in, 1);
    send(C_STOP, 8'h00, 1'b0);
    wait_done(lat, -1);
    chk("absent_scl", scl, 1);
    chk("absent_sda", sda, 1);
    chk("absent_busy", busy, 0);

    // Read from MEM slave with NACK
    send(C_START, 8'h00, 1'b0);
    wait_done(lat, -1);
    send(C_WRITE, 8'hCD, 1'b0);
    wait_done(lat, -1);
    chk("rd_addr_ack", ack_in, 0);
    send(C_READ, 8'h00, 1'b1);
    repeat (1 + 33 * QTR + QTR / 2) @(posedge clk);
    #1;
    chk("nack_scl", scl, 1);
    chk("nack_sda", sda, 1);
    wait_done(lat, -1);
    chk("rd_lat", lat, 36 * QTR + 1);
    chk("rd_data", rx_data, 8'h5A);
    chk("rd_err", err, 0);
    send(C_STOP, 8'h00, 1'b0);
    wait_done(lat, -1);
    chk("rd_stop_busy", busy, 0);

    // Illegal READ with bus free, then STOP with bus free
    send(C_READ, 8'h00, 1'b0);
    wait_done(lat, -1);
    chk("ill_lat", lat, 1);
    chk("ill_err", err, 1);
    chk("ill_scl", scl, 1);
    chk("ill_sda", sda, 1);
    chk("ill_busy", busy, 0);
    chk("ill_rx_hold", rx_data, 8'h5A);
    send(C_STOP, 8'h00, 1'b0);
    wait_done(lat, -1);
    chk("idle_stop_lat", lat, 1);
    chk("idle_stop_err", err, 0);

    // Reset during bit 4 of a WRITE
    send(C_START, 8'h00, 1'b0);
    wait_done(lat, -1);
    send(C_WRITE, 8'hC8, 1'b0);
    repeat (1 + 16 * QTR + 50) @(posedge clk);
    #1;
    chk("pre_rst_scl", scl, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_scl", scl, 1);
    chk("mid_rst_sda", sda, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send(C_START, 8'h00, 1'b0);
    wait_done(lat, -1);
    chk("post_rst_lat", lat, 4 * QTR + 1);
    chk("post_rst_busy", busy, 1);
    send(C_WRITE, 8'hC8, 1'b0);
    wait_done(lat, -1);
    chk("post_rst_ack", ack_in, 0);
    send(C_STOP, 8'h00, 1'b0);
    wait_done(lat, -1);
    chk("post_rst_stop", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
